vr_rr_arbiter: RTL

Round-robin arbiter merging N valid/ready producer streams onto one valid/ready consumer stream. It sits in front of the FIFO put side so that several sources can share one FIFO. A registered one-beat output stage sustains one beat per cycle. Each beat carries the index of the requester that produced it.

---
 rtl/vr_arb_pkg.sv | 19 +
 rtl/vr_rr_arbiter_if.sv | 48 ++++
 rtl/vr_rr_arbiter_rr_picker.sv | 37 +++
 rtl/vr_rr_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/vr_arb_pkg.sv
// Shared constants and helpers for the round-robin valid/ready arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   arb_idw(n)   - width of a requester index, never less than 1 bit
//   ARB_CNT_W    - width of each per-requester grant counter
//   ARB_CNT_MAX  - saturation value of a grant counter
package vr_arb_pkg;

    localparam int ARB_CNT_W = 16;
    localparam logic [ARB_CNT_W-1:0] ARB_CNT_MAX = 16'hFFFF;

    // A single requester still needs a 1-bit index so out_src is never zero-width.
    function automatic int arb_idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vr_rr_arbiter_if.sv
// Bundle of the N producer streams plus the single merged consumer stream.
// Latency: n/a (wires only).
// Backpressure: req_ready / out_ready carry backpressure toward producers.
//
// Signals:
//   req_valid [N]     producer valid          req_ready [N]  producer ready (one-hot or zero)
//   req_data  [N][W]  producer data           out_valid      merged beat valid
//   out_data  [W]     merged beat data        out_src        index of the producing requester
//   out_ready         consumer ready
// Modports: master = traffic side (producers + consumer), slave = arbiter.
interface vr_rr_arbiter_if
    import vr_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) ();

    localparam int IDW = arb_idw(N);

    logic [N-1:0]          req_valid;
    logic [N-1:0][W-1:0]   req_data;
    logic [N-1:0]          req_ready;
    logic                  out_valid;
    logic [W-1:0]          out_data;
    logic [IDW-1:0]        out_src;
    logic                  out_ready;

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src
    );

endinterface

// File: rtl/vr_rr_arbiter_rr_picker.sv
// Round-robin winner selection: first set request at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
//
// Ports: req [N] in, ptr [IDW] in, any out (some request set), winner [IDW] out.
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] winner
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic           found;

    // Two copies of req side by side: masking off everything below ptr and
    // taking the lowest remaining bit gives the wrap-around search without a
    // variable rotate. Bits in the upper copy map back by subtracting N.
    always_comb begin
        dbl    = {req, req};
        masked = dbl & ({(2*N){1'b1}} << ptr);
        any    = |req;
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < 2*N; j++) begin
            if (!found && masked[j]) begin
                found  = 1'b1;
                winner = (j >= N) ? IDW'(j - N) : IDW'(j);
            end
        end
    end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Round-robin merge of N valid/ready streams into one registered valid/ready stream.
// Latency: 1 cycle from acceptance (req_valid & req_ready) to out_valid.
// Backpressure: out_ready=0 with a beat held freezes the output and drops all req_ready.
//
// Ports: clk, reset (async, active-low), bus (vr_rr_arbiter_if.slave).
// Optional (VR_ARB_STATS_EN defined): grant_cnt [N][16] out, stats_clr in --
// saturating per-requester accepted-beat counters with synchronous clear.
module vr_rr_arbiter
    import vr_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    vr_rr_arbiter_if.slave                bus
`ifdef VR_ARB_STATS_EN
    ,
    output logic [N-1:0][ARB_CNT_W-1:0]   grant_cnt,
    input  logic                          stats_clr
`endif
);

    localparam int IDW = arb_idw(N);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] winner;
    logic           any;
    logic           load_en;
    logic           load;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic [IDW-1:0] out_src_q;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    // Stage can take a beat when empty or when its current beat leaves this cycle.
    assign load_en = ~out_valid_q | bus.out_ready;
    assign load    = load_en & any;

    // With N=1 this always yields 0, so ptr stays constant.
    assign ptr_nxt = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;

    // reset is folded in so no producer sees ready while the block is held in reset.
    always_comb begin
        bus.req_ready = '0;
        if (reset && load) begin
            bus.req_ready[winner] = bus.req_valid[winner];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.req_data[winner];
            out_src_q   <= winner;
            ptr_q       <= ptr_nxt;
        end else if (bus.out_ready) begin
            // Drain with nothing to replace it; data/src keep their last values.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

`ifdef VR_ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_cnt
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                grant_cnt[i] <= '0;
            end else if (stats_clr) begin
                grant_cnt[i] <= '0;
            end else if (bus.req_valid[i] && bus.req_ready[i]
                         && (grant_cnt[i] != ARB_CNT_MAX)) begin
                grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule
